// File: rtl/pcie_phy_tx_framer.sv
// PCIe PHY transmit framer: STP/END packet framing, word padding, periodic SKP
// ordered sets and logical idle, striped one symbol per cycle across LANES lanes.
module pcie_phy_tx_framer #(
    parameter int LANES        = 4,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         IN_DATA,
    input  logic               IN_VALID,
    input  logic               IN_LAST,
    output logic               IN_READY,
    output logic [LANES*8-1:0] DATA_OUT,
    output logic [LANES-1:0]   CONTROL_OUT,
    output logic               OUT_VALID,
    output logic               UNDERRUN
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(SKP_INTERVAL - 1);

    localparam logic [7:0] SYM_STP  = 8'hFB;
    localparam logic [7:0] SYM_END  = 8'hFD;
    localparam logic [7:0] SYM_EDB  = 8'hFE;
    localparam logic [7:0] SYM_PAD  = 8'hF7;
    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_IDLE = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE, S_STP, S_DATA, S_END, S_PAD, S_SKP, S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 skp_pending_q, skp_pending_d;
    logic [1:0]           skp_word_q, skp_word_d;
    logic [LANES*8-1:0]   stage_q, stage_d;
    logic [LANES-1:0]     kstage_q, kstage_d;
    logic [LANES*8-1:0]   data_out_q;
    logic [LANES-1:0]     ctrl_out_q;
    logic                 out_valid_q;
    logic                 underrun_q, underrun_d;

    logic       last_lane, timer_wrap, decide, start_ok, enter_skp, sym_k;
    logic [7:0] sym_data;

    assign last_lane  = (lane_q == LAST_LANE);
    assign timer_wrap = (timer_q == TIMER_MAX);

    always_comb begin
        state_d    = state_q;
        skp_word_d = skp_word_q;
        sym_data   = SYM_IDLE;
        sym_k      = 1'b0;
        underrun_d = 1'b0;
        decide     = 1'b0;
        case (state_q)
            S_IDLE: decide = last_lane;
            S_STP: begin
                sym_data = SYM_STP;
                sym_k    = 1'b1;
                state_d  = S_DATA;
            end
            S_DATA: begin
                if (IN_VALID) begin
                    sym_data = IN_DATA;
                    if (IN_LAST) state_d = S_END;
                end else begin
                    sym_data   = SYM_EDB;
                    sym_k      = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = S_DRAIN;
                end
            end
            S_END: begin
                sym_data = SYM_END;
                sym_k    = 1'b1;
                if (last_lane) decide = 1'b1;
                else           state_d = S_PAD;
            end
            S_PAD: begin
                sym_data = SYM_PAD;
                sym_k    = 1'b1;
                decide   = last_lane;
            end
            S_DRAIN: begin
                if (IN_VALID && IN_LAST) begin
                    if (last_lane) decide = 1'b1;
                    else           state_d = S_PAD;
                end
            end
            S_SKP: begin
                sym_data = (skp_word_q == 2'd0) ? SYM_COM : SYM_SKP;
                sym_k    = 1'b1;
                if (last_lane) begin
                    skp_word_d = skp_word_q + 2'd1;
                    decide     = (skp_word_q == 2'd3);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte accepted in DRAIN is the aborted packet's tail, not a new packet request.
        start_ok  = IN_VALID && (state_q != S_DRAIN);
        enter_skp = decide && skp_pending_q;
        if (decide) state_d = skp_pending_q ? S_SKP : (start_ok ? S_STP : S_IDLE);

        skp_pending_d = (skp_pending_q | timer_wrap) & ~enter_skp;
        timer_d       = timer_wrap ? '0 : timer_q + 1'b1;
        lane_d        = last_lane ? '0 : lane_q + 1'b1;

        stage_d  = stage_q;
        kstage_d = kstage_q;
        stage_d[8*int'(lane_q) +: 8] = sym_data;
        kstage_d[lane_q]             = sym_k;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            lane_q        <= '0;
            timer_q       <= '0;
            skp_pending_q <= 1'b0;
            skp_word_q    <= '0;
            stage_q       <= '0;
            kstage_q      <= '0;
            data_out_q    <= '0;
            ctrl_out_q    <= '0;
            out_valid_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            timer_q       <= timer_d;
            skp_pending_q <= skp_pending_d;
            skp_word_q    <= skp_word_d;
            stage_q       <= stage_d;
            kstage_q      <= kstage_d;
            out_valid_q   <= last_lane;
            underrun_q    <= underrun_d;
            if (last_lane) begin
                data_out_q <= stage_d;
                ctrl_out_q <= kstage_d;
            end
        end
    end

    assign IN_READY    = !RESET && ((state_q == S_DATA) || (state_q == S_DRAIN));
    assign DATA_OUT    = data_out_q;
    assign CONTROL_OUT = ctrl_out_q;
    assign OUT_VALID   = out_valid_q;
    assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_pcie_phy_tx_framer.sv
// Self-checking bench for pcie_phy_tx_framer: directed framing/SKP prologue,
// then random packets, stalls and resets against a symbol-schedule model.
module tb_pcie_phy_tx_framer;

    localparam int L  = 4;
    localparam int SI = 52;
    localparam int N_ITER = 3000;

    localparam logic [8:0] K_STP = 9'h1FB, K_END = 9'h1FD, K_EDB = 9'h1FE, K_PAD = 9'h1F7;
    localparam logic [8:0] K_COM = 9'h1BC, K_SKP = 9'h11C, D_IDLE = 9'h000;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [7:0]     IN_DATA = '0;
    logic           IN_VALID = 1'b0;
    logic           IN_LAST = 1'b0;
    logic           IN_READY;
    logic [L*8-1:0] DATA_OUT;
    logic [L-1:0]   CONTROL_OUT;
    logic           OUT_VALID;
    logic           UNDERRUN;

    pcie_phy_tx_framer #(.LANES(L), .SKP_INTERVAL(SI)) dut (
        .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_LAST(IN_LAST), .IN_READY(IN_READY), .DATA_OUT(DATA_OUT),
        .CONTROL_OUT(CONTROL_OUT), .OUT_VALID(OUT_VALID), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: symbols still owed are queued; packets stream byte by byte.
    logic [8:0]     sched[$];
    logic [8:0]     mstage[L];
    int             mode;      // 0 free, 1 streaming packet, 2 discarding aborted packet
    bit             pend;
    int             m_t;
    bit             m_ready;
    logic [L*8-1:0] exp_data;
    logic [L-1:0]   exp_ctrl;
    bit             exp_valid, exp_under;
    logic [35:0]    m_words[$];
    logic [35:0]    d_words[$];

    task automatic model_reset();
        sched.delete();
        mode = 0; pend = 0; m_t = 0; m_ready = 0;
        for (int i = 0; i < L; i++) mstage[i] = '0;
        exp_data = '0; exp_ctrl = '0; exp_valid = 0; exp_under = 0;
    endtask

    task automatic model_step(input bit v, input bit last, input logic [7:0] d, input bit log_en);
        int lane;
        bit wrap, entered;
        logic [8:0] sym;
        lane = m_t % L;
        wrap = ((m_t % SI) == SI - 1);
        m_ready = 0; exp_under = 0; entered = 0;
        if (sched.size() > 0) sym = sched.pop_front();
        else if (mode == 1) begin
            m_ready = 1;
            if (v) begin
                sym = {1'b0, d};
                if (last) begin
                    sched.push_back(K_END);
                    repeat ((L - 1) - ((lane + 1) % L)) sched.push_back(K_PAD);
                    mode = 0;
                end
            end else begin
                sym = K_EDB; exp_under = 1; mode = 2;
            end
        end else if (mode == 2) begin
            m_ready = 1;
            sym = D_IDLE;
            if (v && last) begin
                repeat (L - 1 - lane) sched.push_back(K_PAD);
                mode = 0;
            end
        end else sym = D_IDLE;

        if (lane == L - 1 && sched.size() == 0 && mode == 0) begin
            if (pend) begin
                repeat (L) sched.push_back(K_COM);
                repeat (3 * L) sched.push_back(K_SKP);
                entered = 1;
            end else if (v && !m_ready) begin
                sched.push_back(K_STP);
                mode = 1;
            end
        end
        pend = (pend || wrap) && !entered;

        mstage[lane] = sym;
        exp_valid = (lane == L - 1);
        if (exp_valid) begin
            for (int i = 0; i < L; i++) begin
                exp_data[8*i +: 8] = mstage[i][7:0];
                exp_ctrl[i]        = mstage[i][8];
            end
            if (log_en) m_words.push_back({exp_ctrl, exp_data});
        end
        m_t++;
    endtask

    logic [8:0] src_q[$];
    int  hold_until = 0;
    int  rst_left = 0;
    int  phase = 0;
    bit  armed = 0;
    int  rdy_p1 = 0;
    int  rdy_p2_first = -1;
    int  under_seen = 0;

    task automatic push_pkt(input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : base + 8'(i * 8'h11);
            src_q.push_back({(i == len - 1), b});
        end
    endtask

    logic [35:0] pin_val[8];
    int          pin_idx[8];

    initial begin
        bit do_rst, stall, v;
        model_reset();
        pin_idx = '{0, 4, 5, 7, 8, 14, 15, 17};
        pin_val = '{36'h0_00000000, 36'h1_CCBBAAFB, 36'hF_F7F7F7FD, 36'h1_332211FB,
                    36'hE_F7F7FD44, 36'hF_BCBCBCBC, 36'hF_1C1C1C1C, 36'hF_1C1C1C1C};
        for (int it = 0; it < N_ITER; it++) begin
            @(negedge CLK);
            if (armed) begin
                chk("data_out", 64'(DATA_OUT), 64'(exp_data));
                chk("control_out", 64'(CONTROL_OUT), 64'(exp_ctrl));
                chk("out_valid", 64'(OUT_VALID), 64'(exp_valid));
                chk("underrun", 64'(UNDERRUN), 64'(exp_under));
                if (UNDERRUN === 1'b1) under_seen++;
                if (phase == 0 && OUT_VALID === 1'b1) d_words.push_back({CONTROL_OUT, DATA_OUT});
            end

            if (phase == 0 && armed && m_t == 80) begin
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("model_word%0d", pin_idx[i]),
                        (m_words.size() > pin_idx[i]) ? 64'(m_words[pin_idx[i]]) : 64'hDEAD, 64'(pin_val[i]));
                    chk($sformatf("dut_word%0d", pin_idx[i]),
                        (d_words.size() > pin_idx[i]) ? 64'(d_words[pin_idx[i]]) : 64'hDEAD, 64'(pin_val[i]));
                end
                chk("ready_cycles_pkt1", 64'(rdy_p1), 64'd3);
                chk("ready_first_pkt2", 64'(rdy_p2_first), 64'd29);
                phase = 1;
            end

            do_rst = 0;
            if (it < 3) do_rst = 1;
            else if (rst_left > 0) begin do_rst = 1; rst_left--; end
            else if (phase == 1 && $urandom_range(0, 299) == 0) begin
                do_rst = 1; rst_left = $urandom_range(0, 2);
            end
            if (do_rst) begin src_q.delete(); hold_until = 0; end
            else if (phase == 0) begin
                if (m_t == 0)  begin push_pkt(3, 8'hAA, 0); hold_until = 15; end
                if (m_t == 24) begin push_pkt(4, 8'h11, 0); hold_until = 26; end
            end else if (src_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                push_pkt($urandom_range(1, 12), 8'h00, 1);
                hold_until = m_t + $urandom_range(0, 5);
            end
            stall = (phase == 1) && ($urandom_range(0, 29) == 0);
            v = !do_rst && (src_q.size() > 0) && (m_t >= hold_until) && !stall;

            RESET    = do_rst;
            IN_VALID = v;
            IN_DATA  = v ? src_q[0][7:0] : 8'($urandom);
            IN_LAST  = v ? src_q[0][8] : 1'($urandom);
            #1;
            if (phase == 0 && !do_rst) begin
                if (IN_READY === 1'b1 && m_t < 24) rdy_p1++;
                if (IN_READY === 1'b1 && m_t >= 24 && rdy_p2_first < 0) rdy_p2_first = m_t;
            end
            if (do_rst) begin
                model_reset();
                armed = 1;
            end else begin
                model_step(v, IN_LAST, IN_DATA, phase == 0);
            end
            chk("in_ready", 64'(IN_READY), 64'(m_ready));
            if (v && m_ready) void'(src_q.pop_front());
        end
        chk("underrun_seen", 64'(under_seen > 0), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
